// File: rtl/matmul_pkg.sv
// Shared constants and FSM state encoding for the 2x2 matrix multiply sequencer.
package matmul_pkg;

  localparam int DATA_W = 18;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_A0,
    RD_B0,
    RD_A1,
    RD_B1,
    WR_C,
    DONE
  } state_t;

endpackage

// File: rtl/matmul_seq_mac.sv
// Unsigned multiply-accumulate step with overflow detection.
// Define MATMUL_SAT_EN to clamp overflowing results instead of wrapping.
module matmul_mac #(
  parameter int DATA_W = 18
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              clear,
  output logic [DATA_W-1:0] acc_out,
  output logic              ovf
);

`ifdef MATMUL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [DATA_W-1:0] MAX_VAL = '1;

  function automatic logic [DATA_W-1:0] fit(input logic [DATA_W-1:0] v, input logic o);
    return (o && SAT_EN) ? MAX_VAL : v;
  endfunction

  logic [2*DATA_W-1:0] prod_full;
  logic [DATA_W-1:0]   prod;
  logic [DATA_W-1:0]   base;
  logic [DATA_W:0]     sum_full;
  logic                prod_ovf;
  logic                sum_ovf;

  always_comb begin
    prod_full = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    prod_ovf  = |prod_full[2*DATA_W-1:DATA_W];
    prod      = fit(prod_full[DATA_W-1:0], prod_ovf);
    base      = clear ? '0 : acc_in;
    // A clamped accumulator plus anything nonzero overflows again, so it stays clamped.
    sum_full  = {1'b0, base} + {1'b0, prod};
    sum_ovf   = sum_full[DATA_W];
    acc_out   = fit(sum_full[DATA_W-1:0], sum_ovf);
    ovf       = prod_ovf | sum_ovf;
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer and port arbiter computing C = A x B over a single 2x2 matrix memory port.
// Optional MATMUL_SAT_EN selects saturating arithmetic in the MAC.
module matmul_seq #(
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int N      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  input  logic              host_wr,
  input  logic [1:0]        host_sel,
  input  logic [1:0]        host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_wr,
  output logic [1:0]        mem_sel,
  output logic [1:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import matmul_pkg::*;

  if (N != 2) begin : g_n_check
    $error("matmul_seq supports only N=2");
  end

  state_t            state_q, state_d;
  logic [1:0]        e_q, e_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] a_lat_q, a_lat_d;
  logic              ovf_q, ovf_d;

  logic [1:0]        fsm_sel;
  logic [1:0]        fsm_addr;
  logic              fsm_wr;
  logic              mac_clear;
  logic [DATA_W-1:0] mac_acc;
  logic              mac_ovf;
  logic              idle;

  matmul_mac #(.DATA_W(DATA_W)) u_mac (
    .a      (a_lat_q),
    .b      (mem_rdata),
    .acc_in (acc_q),
    .clear  (mac_clear),
    .acc_out(mac_acc),
    .ovf    (mac_ovf)
  );

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    acc_d     = acc_q;
    a_lat_d   = a_lat_q;
    ovf_d     = ovf_q;
    fsm_sel   = SEL_A;
    fsm_addr  = 2'b00;
    fsm_wr    = 1'b0;
    mac_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_A0;
          e_d     = 2'd0;
          ovf_d   = 1'b0;
        end
      end
      RD_A0: begin
        fsm_addr = {e_q[1], 1'b0};
        a_lat_d  = mem_rdata;
        state_d  = RD_B0;
      end
      RD_B0: begin
        fsm_sel   = SEL_B;
        fsm_addr  = {1'b0, e_q[0]};
        mac_clear = 1'b1;
        acc_d     = mac_acc;
        ovf_d     = ovf_q | mac_ovf;
        state_d   = RD_A1;
      end
      RD_A1: begin
        fsm_addr = {e_q[1], 1'b1};
        a_lat_d  = mem_rdata;
        state_d  = RD_B1;
      end
      RD_B1: begin
        fsm_sel  = SEL_B;
        fsm_addr = {1'b1, e_q[0]};
        acc_d    = mac_acc;
        ovf_d    = ovf_q | mac_ovf;
        state_d  = WR_C;
      end
      WR_C: begin
        fsm_sel  = SEL_C;
        fsm_addr = e_q;
        fsm_wr   = 1'b1;
        if (e_q == 2'd3) begin
          state_d = DONE;
        end else begin
          e_d     = e_q + 2'd1;
          state_d = RD_A0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      e_q     <= 2'd0;
      acc_q   <= '0;
      a_lat_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      a_lat_q <= a_lat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Host owns the port only while idle; a write is never issued during reset.
  assign idle       = (state_q == IDLE);
  assign mem_wr     = !rst && (idle ? host_wr : fsm_wr);
  assign mem_sel    = idle ? host_sel : fsm_sel;
  assign mem_addr   = idle ? host_addr : fsm_addr;
  assign mem_wdata  = idle ? host_wdata : acc_q;
  assign host_rdata = mem_rdata;

  assign busy = !idle;
  assign done = (state_q == DONE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq with a behavioural 4-bank x 4-word memory.
module tb_matmul_seq;
  localparam int W = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, ovf;
  logic          host_wr;
  logic [1:0]    host_sel, host_addr;
  logic [W-1:0]  host_wdata, host_rdata;
  logic          mem_wr;
  logic [1:0]    mem_sel, mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  logic [W-1:0]  mem [0:3][0:3];

  int total = 0;
  int bad   = 0;

  matmul_seq #(.DATA_W(W), .N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .host_wr   (host_wr),
    .host_sel  (host_sel),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .mem_wr    (mem_wr),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_sel][mem_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++)
        for (int a = 0; a < 4; a++)
          mem[s][a] <= '0;
    end else if (mem_wr) begin
      mem[mem_sel][mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] s, input logic [1:0] a, input logic [W-1:0] d);
    host_wr = 1'b1; host_sel = s; host_addr = a; host_wdata = d;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] s, input logic [1:0] a, output logic [W-1:0] d);
    host_sel = s; host_addr = a;
    #1;
    d = host_rdata;
  endtask

  task automatic load(input logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    host_write(2'b00, 2'd0, a0); host_write(2'b00, 2'd1, a1);
    host_write(2'b00, 2'd2, a2); host_write(2'b00, 2'd3, a3);
    host_write(2'b01, 2'd0, b0); host_write(2'b01, 2'd1, b1);
    host_write(2'b01, 2'd2, b2); host_write(2'b01, 2'd3, b3);
  endtask

  // Start is raised for edge 0; any host write already staged completes on that edge.
  task automatic run(input bit blk_wr, input bit extra_start);
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      start   = 1'b0;
      host_wr = 1'b0;
      if (blk_wr && c == 5) begin
        host_wr = 1'b1; host_sel = 2'b00; host_addr = 2'd0; host_wdata = 18'd99;
      end
      if (extra_start && (c == 3 || c == 21)) start = 1'b1;
      #1;
      chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 21));
      chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 21));
      chk($sformatf("mem_wr_c%0d", c), 32'(mem_wr), 32'(c <= 20 && c % 5 == 0));
      if (c == 1) chk("ovf_cleared_on_start", 32'(ovf), 32'd0);
    end
    start = 1'b0; host_wr = 1'b0;
  endtask

  task automatic check_c(input string tag, input logic [W-1:0] c0, c1, c2, c3);
    logic [W-1:0] v;
    host_read(2'b11, 2'd0, v); chk({tag, "_C0"}, 32'(v), 32'(c0));
    host_read(2'b11, 2'd1, v); chk({tag, "_C1"}, 32'(v), 32'(c1));
    host_read(2'b11, 2'd2, v); chk({tag, "_C2"}, 32'(v), 32'(c2));
    host_read(2'b11, 2'd3, v); chk({tag, "_C3"}, 32'(v), 32'(c3));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] ovf_c0;
`ifdef MATMUL_SAT_EN
    ovf_c0 = 18'd262143;
`else
    ovf_c0 = 18'd0;
`endif
    rst = 1'b1; start = 1'b0;
    host_wr = 1'b1; host_sel = 2'b00; host_addr = 2'd0; host_wdata = 18'd7;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_no_write", 32'(mem_wr), 32'd0);
    rst = 1'b0; host_wr = 1'b0;
    #1;
    chk("idle_passthru_sel", 32'(mem_sel), 32'(host_sel));

    // Basic multiply; last B word is written in the same cycle start is raised.
    load(18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd0);
    host_wr = 1'b1; host_sel = 2'b01; host_addr = 2'd3; host_wdata = 18'd8;
    run(1'b0, 1'b0);
    check_c("basic", 18'd19, 18'd22, 18'd43, 18'd50);
    chk("basic_ovf", 32'(ovf), 32'd0);

    // Host write dropped while busy, extra starts ignored.
    host_write(2'b11, 2'd0, 18'd0);
    run(1'b1, 1'b1);
    host_read(2'b00, 2'd0, v);
    chk("blocked_A0", 32'(v), 32'd1);
    check_c("blocked", 18'd19, 18'd22, 18'd43, 18'd50);

    // Overflow case.
    load(18'd131072, 18'd0, 18'd0, 18'd0, 18'd2, 18'd0, 18'd0, 18'd0);
    run(1'b0, 1'b0);
    check_c("ovfrun", ovf_c0, 18'd0, 18'd0, 18'd0);
    chk("ovfrun_ovf", 32'(ovf), 32'd1);

    // New run clears the sticky flag.
    load(18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8);
    run(1'b0, 1'b0);
    chk("rerun_ovf", 32'(ovf), 32'd0);
    check_c("rerun", 18'd19, 18'd22, 18'd43, 18'd50);

    // Reset mid-run during an overflowing run.
    load(18'd131072, 18'd0, 18'd0, 18'd0, 18'd2, 18'd0, 18'd0, 18'd0);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
    end
    chk("midrun_busy", 32'(busy), 32'd1);
    chk("midrun_ovf", 32'(ovf), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_done", 32'(done), 32'd0);
    chk("postrst_ovf", 32'(ovf), 32'd0);
    host_sel = 2'b01; host_addr = 2'd2;
    #1;
    chk("postrst_sel", 32'(mem_sel), 32'd1);
    chk("postrst_addr", 32'(mem_addr), 32'd2);
    tick();
    load(18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8);
    run(1'b0, 1'b0);
    check_c("postrst", 18'd19, 18'd22, 18'd43, 18'd50);
    chk("postrst_final_ovf", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
